ss_bundle_block: RTL
====================

Name: ss_bundle_block

Overview:
Bundling stage downstream of the sparse-segmented bind block. It accumulates a stream of bound sparse block-coded hypervectors (one set bit per segment) into per-position saturating counters. On command it thins the bundle back to a valid sparse vector by taking the per-segment argmax. The result feeds the associative memory / next bind stage.

Parameters:
LENGTH_VECTOR, 32, total hypervector width in bits; must be divisible by SEGMENT_LENGTH
SEGMENT_LENGTH, 8, bits per segment; NUM_SEGMENTS = LENGTH_VECTOR/SEGMENT_LENGTH (localparam)
COUNT_WIDTH, 4, width of each position counter and of num_bundled; saturates at 2^COUNT_WIDTH-1

Ports:
clk  input  1  clock, rising edge
arst_n_in  input  1  asynchronous active-low reset
hv_in  input  LENGTH_VECTOR  bound hypervector to accumulate
in_valid  input  1  hv_in valid this cycle
in_ready  output  1  block accepts hv_in; high only in ACCUM
finalize  input  1  request thinning of current bundle
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse, hv_out updated
hv_out  output  LENGTH_VECTOR  thinned bundle, one set bit per segment; held until next done
num_bundled  output  COUNT_WIDTH  vectors accepted since last done, saturating

Behaviour:
- Reset (async, any state, including mid-SCAN): state ACCUM, all counters 0, hv_out 0, done 0, num_bundled 0, scan index 0. In-flight scan is discarded.
- States: ACCUM, SCAN, DONE.
- ACCUM: in_ready=1, busy=0. Accept when in_valid=1. For every bit i with hv_in[i]=1, counter[i] += 1, saturating at max. num_bundled += 1, saturating. No sparsity check; multi-hot segments are accumulated as given.
- ACCUM with finalize=1: go to SCAN next cycle. If in_valid=1 in the same cycle, that vector is accumulated first and is included in the scan.
- SCAN: in_ready=0. Runs SEGMENT_LENGTH cycles; scan index j = 0..SEGMENT_LENGTH-1, one position per cycle, all segments in parallel.
  - Each segment keeps max_val (init 0) and arg (init 0).
  - Update when counter[seg*SEGMENT_LENGTH+j] > max_val (strict compare). Ties therefore resolve to the lowest index.
  - A segment with all-zero counts yields position 0.
  - in_valid and finalize are ignored.
- DONE (1 cycle):
  - hv_out <= one-hot per segment at arg; done=1.
  - All counters, num_bundled and scan state are cleared.
  - Next state ACCUM.
- Latency: finalize sampled at edge t -> SCAN for SEGMENT_LENGTH cycles -> done high in cycle t+SEGMENT_LENGTH+1 (9 cycles for default).
- finalize with zero vectors accumulated is legal: hv_out = bit 0 of every segment.

Optional Feature:
SS_BUNDLE_ONEHOT_CHECK_EN: adds output port err_onehot (1 bit).
- err_onehot is a sticky flag, set when an accepted hv_in has any segment whose popcount is not 1.
- It is cleared by reset and in the DONE cycle; the clear applies after DONE, so the flag is visible during DONE.
- Without the macro: the port is absent and there is no check logic.

Test Plan:
1. Reset asserted then released -> hv_out=0x00000000, done=0, in_ready=1, busy=0, num_bundled=0.
2. Accept 0x01010101 twice and 0x02020202 once, then finalize -> done exactly 9 cycles after the finalize edge, hv_out=0x01010101, num_bundled returns to 0.
3. Tie: accept 0x10101010 and 0x01010101 once each, then finalize -> hv_out=0x01010101 (lowest index wins).
4. Saturation: 20x 0x02020202 and 15x 0x04040404 -> both saturate at 15, num_bundled=15, hv_out=0x02020202.
5. in_valid=1 with hv_in=0x08080808 and finalize=1 in the same cycle from an empty bundle -> hv_out=0x08080808. With SS_BUNDLE_ONEHOT_CHECK_EN, accepting 0x03000000 sets err_onehot=1.
6. After one accepted vector, pulse arst_n_in low in the 3rd SCAN cycle -> done never pulses, hv_out=0, state ACCUM. A following finalize with no input -> hv_out=0x01010101.

Source files
------------

// File: rtl/ss_bundle_block.sv
// ss_bundle_block
// Bundling stage for sparse block-coded hypervectors. Each segment of a
// hypervector normally has exactly one set bit. This block adds accepted
// vectors into per-bit saturating counters. On finalize it thins the bundle
// back to a sparse vector by taking the argmax inside every segment.
//
// Optional feature: define SS_BUNDLE_ONEHOT_CHECK_EN to add the err_onehot
// output. It is a sticky flag that is set when an accepted vector has a
// segment whose popcount is not exactly one.
//
// Ports:
//   clk          rising-edge clock
//   arst_n_in    asynchronous active-low reset
//   hv_in        bound hypervector to accumulate
//   in_valid     hv_in valid this cycle
//   in_ready     high only while accumulating (ACCUM)
//   finalize     request thinning of the current bundle
//   busy         high while scanning or completing (SCAN, DONE)
//   done         one-cycle pulse; hv_out carries the new result
//   hv_out       thinned bundle with one set bit per segment, held until next done
//   num_bundled  vectors accepted since the last done, saturating
//   err_onehot   (optional) sticky non-one-hot segment flag
module ss_bundle_block #(
  parameter int LENGTH_VECTOR  = 32,
  parameter int SEGMENT_LENGTH = 8,
  parameter int COUNT_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [LENGTH_VECTOR-1:0] hv_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     finalize,
  output logic                     busy,
  output logic                     done,
  output logic [LENGTH_VECTOR-1:0] hv_out,
`ifdef SS_BUNDLE_ONEHOT_CHECK_EN
  output logic                     err_onehot,
`endif
  output logic [COUNT_WIDTH-1:0]   num_bundled
);

  localparam int NUM_SEGMENTS = LENGTH_VECTOR / SEGMENT_LENGTH;
  localparam int IDX_W        = (SEGMENT_LENGTH > 1) ? $clog2(SEGMENT_LENGTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(SEGMENT_LENGTH - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counters [LENGTH_VECTOR];
  logic [COUNT_WIDTH-1:0] max_val  [NUM_SEGMENTS];
  logic [IDX_W-1:0]       arg      [NUM_SEGMENTS];
  logic [IDX_W-1:0]       scan_idx;

  logic [COUNT_WIDTH-1:0] cur_cnt  [NUM_SEGMENTS];
  logic [COUNT_WIDTH-1:0] next_max [NUM_SEGMENTS];
  logic [IDX_W-1:0]       next_arg [NUM_SEGMENTS];
  logic [LENGTH_VECTOR-1:0] next_hv;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != ACCUM);

  // Per-segment argmax step for the current scan position. A strict compare
  // keeps the earliest maximum, so ties and all-zero segments resolve to the
  // lowest index. next_hv is the one-hot encoding of the updated args. On the
  // last scan cycle it already includes the final position, so the result can
  // be registered together with done.
  always_comb begin
    next_hv = '0;
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      cur_cnt[s] = '0;
      for (int j = 0; j < SEGMENT_LENGTH; j++) begin
        if (scan_idx == IDX_W'(j)) begin
          cur_cnt[s] = counters[s*SEGMENT_LENGTH + j];
        end
      end
      next_max[s] = max_val[s];
      next_arg[s] = arg[s];
      if (cur_cnt[s] > max_val[s]) begin
        next_max[s] = cur_cnt[s];
        next_arg[s] = scan_idx;
      end
      for (int j = 0; j < SEGMENT_LENGTH; j++) begin
        next_hv[s*SEGMENT_LENGTH + j] = (next_arg[s] == IDX_W'(j));
      end
    end
  end

`ifdef SS_BUNDLE_ONEHOT_CHECK_EN
  logic hv_in_bad;

  // Flags any segment of the incoming vector that is not exactly one-hot.
  always_comb begin
    hv_in_bad = 1'b0;
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      if ($countones(hv_in[s*SEGMENT_LENGTH +: SEGMENT_LENGTH]) != 1) begin
        hv_in_bad = 1'b1;
      end
    end
  end
`endif

  // Main control. In ACCUM, accepted vectors bump the saturating counters.
  // SCAN walks one position per cycle across all segments in parallel, then
  // registers the thinned vector and raises done on entry to DONE. DONE clears
  // the bundle so the next accumulation starts from empty.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state       <= ACCUM;
      scan_idx    <= '0;
      done        <= 1'b0;
      hv_out      <= '0;
      num_bundled <= '0;
      for (int i = 0; i < LENGTH_VECTOR; i++) counters[i] <= '0;
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        max_val[s] <= '0;
        arg[s]     <= '0;
      end
`ifdef SS_BUNDLE_ONEHOT_CHECK_EN
      err_onehot  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < LENGTH_VECTOR; i++) begin
              if (hv_in[i] && (counters[i] != CNT_MAX)) begin
                counters[i] <= counters[i] + 1'b1;
              end
            end
            if (num_bundled != CNT_MAX) begin
              num_bundled <= num_bundled + 1'b1;
            end
`ifdef SS_BUNDLE_ONEHOT_CHECK_EN
            if (hv_in_bad) err_onehot <= 1'b1;
`endif
          end
          if (finalize) begin
            state    <= SCAN;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          for (int s = 0; s < NUM_SEGMENTS; s++) begin
            max_val[s] <= next_max[s];
            arg[s]     <= next_arg[s];
          end
          if (scan_idx == IDX_LAST) begin
            hv_out <= next_hv;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE: begin
          scan_idx    <= '0;
          num_bundled <= '0;
          for (int i = 0; i < LENGTH_VECTOR; i++) counters[i] <= '0;
          for (int s = 0; s < NUM_SEGMENTS; s++) begin
            max_val[s] <= '0;
            arg[s]     <= '0;
          end
`ifdef SS_BUNDLE_ONEHOT_CHECK_EN
          err_onehot  <= 1'b0;
`endif
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
